// File: rtl/soc_ctrl_pkg.sv
// Shared SoC control definitions.
// Divider widths and the PLL sequencer state encoding.
package soc_ctrl_pkg;

  localparam int REF_DIV_BW = 4;
  localparam int FB_DIV_BW  = 12;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    RESET,
    PROG,
    LOCK_WAIT,
    UNGATE,
    RELEASE
  } pll_seq_state_e;

endpackage

// File: rtl/soc_pll_seq.sv
// Per-domain PLL retune sequencer: gate, reset, program, lock, ungate, release.
// Define SOC_PLL_SEQ_TIMEOUT_EN to bound LOCK_WAIT by LOCK_TIMEOUT cycles.
module soc_pll_seq #(
  parameter int REF_DIV_BW   = soc_ctrl_pkg::REF_DIV_BW,
  parameter int FB_DIV_BW    = soc_ctrl_pkg::FB_DIV_BW,
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RST_REF_DIV  = 1,
  parameter int RST_FB_DIV   = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_i,
  input  logic [REF_DIV_BW-1:0] req_ref_div_i,
  input  logic [FB_DIV_BW-1:0]  req_fb_div_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [REF_DIV_BW-1:0] pll_ref_div_o,
  output logic [FB_DIV_BW-1:0]  pll_fb_div_o,
  input  logic                  pll_locked_i,
  output logic                  dom_clk_en_o,
  output logic                  dom_arst_n_o
);

  import soc_ctrl_pkg::*;

  localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LT_LD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLANK_END =
    CNT_W'(LOCK_TIMEOUT - 1 - SETTLE_CYC);

  localparam logic [REF_DIV_BW-1:0] RST_REF = REF_DIV_BW'(RST_REF_DIV);
  localparam logic [FB_DIV_BW-1:0]  RST_FB  = FB_DIV_BW'(RST_FB_DIV);

  pll_seq_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REF_DIV_BW-1:0] ref_cap_q, ref_cap_d;
  logic [FB_DIV_BW-1:0]  fb_cap_q, fb_cap_d;
  logic [REF_DIV_BW-1:0] ref_div_q, ref_div_d;
  logic [FB_DIV_BW-1:0]  fb_div_q, fb_div_d;
  logic                  clk_en_q, clk_en_d;
  logic                  rst_n_q, rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic req_ok;
  logic blank_done;

  assign req_ok = (req_ref_div_i != '0) && (req_fb_div_i != '0);
  // counter counts down from LT_LD, so elapsed >= SETTLE_CYC here
  assign blank_done = (cnt_q <= BLANK_END);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    ref_cap_d = ref_cap_q;
    fb_cap_d  = fb_cap_q;
    ref_div_d = ref_div_q;
    fb_div_d  = fb_div_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    err_d     = err_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (req_i && req_ok): begin
            ref_cap_d = req_ref_div_i;
            fb_cap_d  = req_fb_div_i;
            err_d     = 1'b0;
            clk_en_d  = 1'b0;
            cnt_d     = SET_LD;
            state_d   = GATE;
          end
          (req_i && !req_ok): begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
          default: ;
        endcase
      end
      GATE: begin
        if (cnt_q == '0) begin
          rst_n_d = 1'b0;
          cnt_d   = SET_LD;
          state_d = RESET;
        end
      end
      RESET: begin
        if (cnt_q == '0) begin
          state_d = PROG;
        end
      end
      PROG: begin
        ref_div_d = ref_cap_q;
        fb_div_d  = fb_cap_q;
        cnt_d     = LT_LD;
        state_d   = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (blank_done && pll_locked_i) begin
          clk_en_d = 1'b1;
          cnt_d    = SET_LD;
          state_d  = UNGATE;
        end
`ifdef SOC_PLL_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      UNGATE: begin
        if (cnt_q == '0) begin
          rst_n_d = 1'b1;
          done_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= RESET;
      cnt_q     <= SET_LD;
      ref_cap_q <= RST_REF;
      fb_cap_q  <= RST_FB;
      ref_div_q <= RST_REF;
      fb_div_q  <= RST_FB;
      clk_en_q  <= 1'b0;
      rst_n_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cap_q <= ref_cap_d;
      fb_cap_q  <= fb_cap_d;
      ref_div_q <= ref_div_d;
      fb_div_q  <= fb_div_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign pll_ref_div_o = ref_div_q;
  assign pll_fb_div_o  = fb_div_q;
  assign dom_clk_en_o  = clk_en_q;
  assign dom_arst_n_o  = rst_n_q;

endmodule

// File: tb/tb_soc_pll_seq.sv
// Directed bench for soc_pll_seq with SETTLE_CYC=4, LOCK_TIMEOUT=64.
// Timeout checks follow SOC_PLL_SEQ_TIMEOUT_EN.
module tb_soc_pll_seq;

  logic        clk;
  logic        arst_n;
  logic        req;
  logic [3:0]  req_ref;
  logic [11:0] req_fb;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  ref_div;
  logic [11:0] fb_div;
  logic        locked;
  logic        clk_en;
  logic        dom_rst_n;

  int nvec;
  int nerr;
  int cyc;
  int ndone;

  soc_pll_seq #(
    .REF_DIV_BW  (4),
    .FB_DIV_BW   (12),
    .SETTLE_CYC  (4),
    .LOCK_TIMEOUT(64),
    .RST_REF_DIV (1),
    .RST_FB_DIV  (1)
  ) dut (
    .clk_i        (clk),
    .arst_ni      (arst_n),
    .req_i        (req),
    .req_ref_div_i(req_ref),
    .req_fb_div_i (req_fb),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .pll_ref_div_o(ref_div),
    .pll_fb_div_o (fb_div),
    .pll_locked_i (locked),
    .dom_clk_en_o (clk_en),
    .dom_arst_n_o (dom_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to the sample point (negedge) of cycle n
  task automatic go(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_req(input logic [3:0] r, input logic [11:0] f);
    req     = 1'b1;
    req_ref = r;
    req_fb  = f;
    cyc     = 0;
    @(negedge clk);
    cyc = 1;
    req = 1'b0;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_clken"}, {31'd0, clk_en}, 32'd0);
    chk({tag, "_rstn"}, {31'd0, dom_rst_n}, 32'd0);
    chk({tag, "_ref"}, {28'd0, ref_div}, 32'd1);
    chk({tag, "_fb"}, {20'd0, fb_div}, 32'd1);
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    cyc     = 0;
    arst_n  = 1'b0;
    req     = 1'b0;
    req_ref = '0;
    req_fb  = '0;
    locked  = 1'b1;

    // power-on bring-up
    repeat (3) @(negedge clk);
    chk_rst_vals("por");
    arst_n = 1'b1;
    cyc    = 0;
    for (int c = 0; c <= 9; c++) begin
      go(c);
      chk("bu_gated", {30'd0, clk_en, dom_rst_n}, 32'd0);
    end
    go(10);
    chk("bu_ungate", {30'd0, clk_en, dom_rst_n}, 32'd2);
    go(13);
    chk("bu_done13", {31'd0, done}, 32'd0);
    go(14);
    chk("bu_done14", {29'd0, done, clk_en, dom_rst_n}, 32'd7);
    chk("bu_busy14", {31'd0, busy}, 32'd1);
    go(15);
    chk("bu_busy15", {30'd0, busy, done}, 32'd0);
    chk("bu_div", {16'd0, ref_div, fb_div}, {16'd0, 4'd1, 12'd1});

    // retune with lock held high
    go(17);
    pulse_req(4'd3, 12'd100);
    chk("rt_gate1", {29'd0, busy, clk_en, dom_rst_n}, 32'h5);
    go(4);
    chk("rt_rstn4", {31'd0, dom_rst_n}, 32'd1);
    go(5);
    chk("rt_rstn5", {31'd0, dom_rst_n}, 32'd0);
    go(9);
    chk("rt_div9", {16'd0, ref_div, fb_div}, {16'd0, 4'd1, 12'd1});
    go(10);
    chk("rt_div10", {16'd0, ref_div, fb_div}, {16'd0, 4'd3, 12'd100});
    go(14);
    chk("rt_clken14", {31'd0, clk_en}, 32'd0);
    go(15);
    chk("rt_ungate15", {30'd0, clk_en, dom_rst_n}, 32'd2);
    go(18);
    chk("rt_done18", {30'd0, done, dom_rst_n}, 32'd0);
    go(19);
    chk("rt_done19", {29'd0, done, dom_rst_n, busy}, 32'h7);
    go(20);
    chk("rt_idle20", {29'd0, done, busy, err}, 32'd0);

    // late lock
    go(22);
    locked = 1'b0;
    pulse_req(4'd5, 12'd200);
    go(30);
    chk("ll_wait30", {30'd0, clk_en, busy}, 32'd1);
    locked = 1'b1;
    go(31);
    chk("ll_ungate31", {30'd0, clk_en, dom_rst_n}, 32'd2);
    go(34);
    chk("ll_done34", {31'd0, done}, 32'd0);
    go(35);
    chk("ll_done35", {30'd0, done, dom_rst_n}, 32'd3);
    chk("ll_div", {16'd0, ref_div, fb_div}, {16'd0, 4'd5, 12'd200});

    // request during GATE is ignored
    go(37);
    pulse_req(4'd2, 12'd50);
    go(2);
    req     = 1'b1;
    req_ref = 4'd7;
    req_fb  = 12'd7;
    go(3);
    req   = 1'b0;
    ndone = 0;
    for (int c = 3; c <= 25; c++) begin
      go(c);
      if (done) ndone++;
    end
    chk("ig_ndone", ndone, 32'd1);
    chk("ig_div", {16'd0, ref_div, fb_div}, {16'd0, 4'd2, 12'd50});
    chk("ig_idle", {31'd0, busy}, 32'd0);

    // invalid requests
    go(27);
    pulse_req(4'd9, 12'd0);
    chk("iv_fb0", {27'd0, err, done, busy, clk_en, dom_rst_n}, 32'h1B);
    chk("iv_div", {16'd0, ref_div, fb_div}, {16'd0, 4'd2, 12'd50});
    go(2);
    chk("iv_sticky", {30'd0, err, done}, 32'd2);
    go(3);
    pulse_req(4'd0, 12'd5);
    chk("iv_ref0", {29'd0, err, done, busy}, 32'h6);
    go(3);
    pulse_req(4'd3, 12'd100);
    chk("iv_clear", {30'd0, err, busy}, 32'd1);
    go(19);
    chk("iv_rt_done", {31'd0, done}, 32'd1);

`ifdef SOC_PLL_SEQ_TIMEOUT_EN
    // lock never rises: timeout
    go(21);
    locked = 1'b0;
    pulse_req(4'd4, 12'd8);
    go(73);
    chk("to_wait73", {30'd0, busy, done}, 32'd2);
    go(74);
    chk("to_exp74",
        {27'd0, err, done, busy, clk_en, dom_rst_n}, 32'h18);
    go(75);
    chk("to_pulse75", {30'd0, err, done}, 32'd2);
    locked = 1'b1;
    go(77);
    pulse_req(4'd4, 12'd8);
    chk("to_clear", {30'd0, err, busy}, 32'd1);
    go(19);
    chk("to_rt_done", {29'd0, done, clk_en, dom_rst_n}, 32'h7);
`else
    // no timeout: waits for lock indefinitely
    go(21);
    locked = 1'b0;
    pulse_req(4'd4, 12'd8);
    go(100);
    chk("nt_wait100", {28'd0, busy, err, done, clk_en}, 32'h8);
    locked = 1'b1;
    go(101);
    chk("nt_ungate", {31'd0, clk_en}, 32'd1);
    go(105);
    chk("nt_done", {29'd0, done, err, dom_rst_n}, 32'h5);
`endif

    // async reset during LOCK_WAIT
    go(cyc + 2);
    locked = 1'b0;
    pulse_req(4'd6, 12'd60);
    go(12);
    arst_n = 1'b0;
    #1;
    chk_rst_vals("ar");
    @(negedge clk);
    arst_n = 1'b1;
    locked = 1'b1;
    cyc    = 0;
    go(9);
    chk("ar_gated9", {30'd0, clk_en, dom_rst_n}, 32'd0);
    go(13);
    chk("ar_done13", {31'd0, done}, 32'd0);
    go(14);
    chk("ar_done14", {29'd0, done, clk_en, dom_rst_n}, 32'h7);
    chk("ar_div", {16'd0, ref_div, fb_div}, {16'd0, 4'd1, 12'd1});
    go(15);
    chk("ar_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
